// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive-side sequencer for a UART. Synchronises the raw rx line, enables
//   the external baud sampler on a start edge, shifts one frame in using the
//   sampler's mid-bit pulses, checks start/parity/stop and hands the byte to
//   a consumer over a valid/ready handshake.
//
// Ports
//   sysclk        in   system clock, all logic on the rising edge
//   rst_n         in   asynchronous active-low reset
//   rx            in   raw serial line, idle high, asynchronous to sysclk
//   sample_en     out  sampler enable; low holds the sampler count at zero
//   sample_pulse  in   one-cycle mid-bit strobe from the sampler
//   rx_data       out  received byte, stable while rx_valid is high
//   rx_valid      out  rx_data holds an unconsumed byte
//   rx_ready      in   consumer takes rx_data when rx_valid & rx_ready
//   frame_err     out  one-cycle pulse: stop bit sampled low
//   parity_err    out  one-cycle pulse: parity mismatch
//   overrun       out  one-cycle pulse: good frame dropped, holding reg full
//   busy          out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_BITS   = 8,  // 5..9, LSB first
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2   // 2..3
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 sample_en,
    input  logic                 sample_pulse,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BRK    = 3'd5;

    localparam int CNT_W = $clog2(DATA_BITS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_d;
    logic                   fall;
    logic [2:0]             state;
    logic [2:0]             state_next;
    logic                   en_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   last_bit;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad;
    logic                   parity_exp;
    logic                   deliver;
    logic                   frame_bad;
    logic                   parity_bad;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign fall       = rx_s_d & ~rx_s;
    assign last_bit   = (bit_cnt == CNT_W'(DATA_BITS - 1));
    // Even parity bit equals XOR of the data; odd parity is its complement.
    assign parity_exp = (^shreg) ^ (PARITY_ODD != 0);
    assign busy       = (state != S_IDLE);

    // Next-state decode; also flags the single cycle in which the frame's
    // fate (deliver, frame error, parity error) is decided.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        deliver    = 1'b0;
        frame_bad  = 1'b0;
        parity_bad = 1'b0;
        case (state)
            S_IDLE:   if (fall) state_next = S_START;
            // A start bit that is high again at mid-bit was a glitch.
            S_START:  if (sample_pulse) state_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (sample_pulse && last_bit)
                          state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (sample_pulse) state_next = S_STOP;
            S_STOP: begin
                if (sample_pulse) begin
                    if (!rx_s) begin
                        // Low stop bit: report once, then sit out the break.
                        state_next = S_BRK;
                        frame_bad  = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        if (par_bad) parity_bad = 1'b1;
                        else         deliver    = 1'b1;
                    end
                end
            end
            S_BRK:    if (rx_s) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign en_next = (state_next == S_START) || (state_next == S_DATA) ||
                     (state_next == S_PARITY) || (state_next == S_STOP);

    // Synchroniser, edge detect, state and sampler enable.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            // Line idles high, so preset the synchroniser to avoid a false start edge.
            sync_q    <= '1;
            rx_s_d    <= 1'b1;
            state     <= S_IDLE;
            sample_en <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_d    <= rx_s;
            state     <= state_next;
            sample_en <= en_next;
        end
    end

    // Frame datapath: bit counter, shift register, parity check.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift register is plain flops, not a RAM, so it is reset too; no partial byte survives a reset.
            bit_cnt <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else if (sample_pulse) begin
            case (state)
                S_START: begin
                    bit_cnt <= '0;
                    par_bad <= 1'b0;
                end
                S_DATA: begin
                    // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
                    shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_PARITY: par_bad <= (rx_s != parity_exp);
                default: ;
            endcase
        end
    end

    // Holding register, handshake and error pulses.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_bad;
            parity_err <= parity_bad;
            // A byte still waiting and not taken this cycle wins over the new one.
            overrun    <= deliver & rx_valid & ~rx_ready;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Directed bench for uart_rx_ctrl. Two instances: one without parity and
//   one with even parity, each driven by its own behavioural baud sampler
//   (bit period P cycles, first pulse P/2 after enable, then every P).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int P = 32;  // sampler period in sysclk cycles

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       rx     = 1'b1;
    logic       rx_ready = 1'b0;
    logic       sample_en, sample_pulse;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, busy;

    logic       rx_p = 1'b1;
    logic       rx_ready_p = 1'b1;
    logic       sample_en_p, sample_pulse_p;
    logic [7:0] rx_data_p;
    logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Event monitors, sampled on the falling edge.
    int         n_fe = 0, n_pe = 0, n_ov = 0, n_acc = 0, n_vcyc = 0, n_olap = 0;
    int         n_fe_p = 0, n_pe_p = 0, n_acc_p = 0;
    logic [7:0] last_acc = 8'h00, last_acc_p = 8'h00;
    logic       valid_q = 1'b0;
    int         t_valid = 0;
    int         t_start = 0;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .rx(rx), .sample_en(sample_en),
        .sample_pulse(sample_pulse), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy)
    );

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) dut_p (
        .sysclk(sysclk), .rst_n(rst_n), .rx(rx_p), .sample_en(sample_en_p),
        .sample_pulse(sample_pulse_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
        .rx_ready(rx_ready_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
        .overrun(overrun_p), .busy(busy_p)
    );

    // Behavioural samplers.
    int scnt, scnt_p;
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= 0; sample_pulse <= 1'b0;
        end else if (!sample_en) begin
            scnt <= 0; sample_pulse <= 1'b0;
        end else begin
            scnt <= (scnt == P-1) ? 0 : scnt + 1;
            sample_pulse <= (scnt == P/2 - 1);
        end
    end
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            scnt_p <= 0; sample_pulse_p <= 1'b0;
        end else if (!sample_en_p) begin
            scnt_p <= 0; sample_pulse_p <= 1'b0;
        end else begin
            scnt_p <= (scnt_p == P-1) ? 0 : scnt_p + 1;
            sample_pulse_p <= (scnt_p == P/2 - 1);
        end
    end

    always @(negedge sysclk) begin
        if (frame_err)  n_fe <= n_fe + 1;
        if (parity_err) n_pe <= n_pe + 1;
        if (overrun)    n_ov <= n_ov + 1;
        if (int'(frame_err) + int'(parity_err) + int'(overrun) > 1) n_olap <= n_olap + 1;
        if (rx_valid) n_vcyc <= n_vcyc + 1;
        if (rx_valid && rx_ready) begin
            n_acc <= n_acc + 1; last_acc <= rx_data;
        end
        if (rx_valid && !valid_q) t_valid <= cyc;
        valid_q <= rx_valid;
        if (frame_err_p)  n_fe_p <= n_fe_p + 1;
        if (parity_err_p) n_pe_p <= n_pe_p + 1;
        if (rx_valid_p && rx_ready_p) begin
            n_acc_p <= n_acc_p + 1; last_acc_p <= rx_data_p;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input bit on_p, input int n);
        if (on_p) rx_p = b; else rx = b;
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Start, 8 data bits LSB first, optional parity, stop. The line is left
    // at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit, input bit on_p);
        @(posedge sysclk);
        #1;
        t_start = cyc;
        drive_bit(1'b0, on_p, P);
        for (int i = 0; i < 8; i++) drive_bit(d[i], on_p, P);
        if (par_en) drive_bit(par_bit, on_p, P);
        drive_bit(stop_bit, on_p, P);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        checks++; if (sample_en !== 1'b0) begin failures++; $display("FAIL reset_sample_en: got %b want 0", sample_en); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin failures++; $display("FAIL reset_errs: got %b want 000", {frame_err, parity_err, overrun}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        idle(4);
        checks++; if (busy !== 1'b0 || sample_en !== 1'b0) begin failures++; $display("FAIL idle_after_reset: busy=%b sample_en=%b want 0 0", busy, sample_en); end
    endtask

    task automatic test_frame;
        int acc0, fe0, pe0, ov0, vc0, lat;
        acc0 = n_acc; fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; vc0 = n_vcyc;
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(P);
        lat = t_valid - t_start;
        checks++; if (n_acc - acc0 !== 1) begin failures++; $display("FAIL frame_accepts: got %0d want 1", n_acc - acc0); end
        checks++; if (last_acc !== 8'hA5) begin failures++; $display("FAIL frame_data: got %h want a5", last_acc); end
        checks++; if (n_vcyc - vc0 !== 1) begin failures++; $display("FAIL frame_valid_cycles: got %0d want 1", n_vcyc - vc0); end
        checks++; if (n_fe - fe0 + n_pe - pe0 + n_ov - ov0 !== 0) begin failures++; $display("FAIL frame_flags: got %0d want 0", n_fe - fe0 + n_pe - pe0 + n_ov - ov0); end
        // 9.5 bit periods after the start edge plus synchroniser/sampler pipeline.
        checks++; if (lat < 9*P + P/2 || lat > 9*P + P/2 + 8) begin failures++; $display("FAIL frame_latency: got %0d want %0d..%0d", lat, 9*P + P/2, 9*P + P/2 + 8); end
        checks++; if (busy !== 1'b0 || sample_en !== 1'b0) begin failures++; $display("FAIL frame_idle: busy=%b sample_en=%b want 0 0", busy, sample_en); end
    endtask

    task automatic test_glitch;
        int acc0, fe0, pe0;
        acc0 = n_acc; fe0 = n_fe; pe0 = n_pe;
        @(posedge sysclk);
        #1;
        rx = 1'b0;
        idle(8);
        rx = 1'b1;
        checks++; if (sample_en !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL glitch_start: sample_en=%b busy=%b want 1 1", sample_en, busy); end
        idle(22);
        checks++; if (sample_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL glitch_drop: sample_en=%b busy=%b want 0 0", sample_en, busy); end
        idle(P);
        checks++; if (n_acc - acc0 + n_fe - fe0 + n_pe - pe0 !== 0) begin failures++; $display("FAIL glitch_events: got %0d want 0", n_acc - acc0 + n_fe - fe0 + n_pe - pe0); end
    endtask

    task automatic test_break;
        int acc0, fe0;
        acc0 = n_acc; fe0 = n_fe;
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4*P);
        checks++; if (n_fe - fe0 !== 1) begin failures++; $display("FAIL break_frame_err: got %0d want 1", n_fe - fe0); end
        checks++; if (n_acc - acc0 !== 0) begin failures++; $display("FAIL break_no_valid: got %0d want 0", n_acc - acc0); end
        checks++; if (busy !== 1'b1 || sample_en !== 1'b0) begin failures++; $display("FAIL break_busy: busy=%b sample_en=%b want 1 0", busy, sample_en); end
        rx = 1'b1;
        idle(6);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_release: got busy=%b want 0", busy); end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(P);
        checks++; if (last_acc !== 8'h81 || n_acc - acc0 !== 1) begin failures++; $display("FAIL break_next_frame: got %h/%0d want 81/1", last_acc, n_acc - acc0); end
        checks++; if (n_fe - fe0 !== 1) begin failures++; $display("FAIL break_single_flag: got %0d want 1", n_fe - fe0); end
    endtask

    task automatic test_overrun;
        int ov0;
        ov0 = n_ov;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(P);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(P);
        checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin failures++; $display("FAIL overrun_hold: got %h/%b want 11/1", rx_data, rx_valid); end
        checks++; if (n_ov - ov0 !== 1) begin failures++; $display("FAIL overrun_pulse: got %0d want 1", n_ov - ov0); end
        // Raise rx_ready only for the cycle in which the third frame is delivered.
        fork
            send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (9*P + P/2 + 4) @(posedge sysclk);
                #1 rx_ready = 1'b1;
                @(posedge sysclk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(4);
        checks++; if (rx_data !== 8'h33 || rx_valid !== 1'b1) begin failures++; $display("FAIL overrun_swap: got %h/%b want 33/1", rx_data, rx_valid); end
        checks++; if (n_ov - ov0 !== 1) begin failures++; $display("FAIL overrun_none_on_swap: got %0d want 1", n_ov - ov0); end
        rx_ready = 1'b1;
        idle(2);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL overrun_drain: got %b want 0", rx_valid); end
    endtask

    task automatic test_parity;
        int acc0, pe0, fe0;
        acc0 = n_acc_p; pe0 = n_pe_p; fe0 = n_fe_p;
        // 0x07 has three ones: even parity bit is 1.
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(P);
        checks++; if (n_acc_p - acc0 !== 1 || last_acc_p !== 8'h07) begin failures++; $display("FAIL parity_good: got %0d/%h want 1/07", n_acc_p - acc0, last_acc_p); end
        checks++; if (n_pe_p - pe0 !== 0) begin failures++; $display("FAIL parity_good_flag: got %0d want 0", n_pe_p - pe0); end
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(P);
        checks++; if (n_pe_p - pe0 !== 1) begin failures++; $display("FAIL parity_bad_flag: got %0d want 1", n_pe_p - pe0); end
        checks++; if (n_acc_p - acc0 !== 1 || n_fe_p - fe0 !== 0) begin failures++; $display("FAIL parity_bad_only: acc=%0d fe=%0d want 1 0", n_acc_p - acc0, n_fe_p - fe0); end
    endtask

    task automatic test_reset_mid;
        int acc0;
        logic [7:0] d;
        d = 8'hC3;
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(P);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h99) begin failures++; $display("FAIL midreset_pre: got %b/%h want 1/99", rx_valid, rx_data); end
        @(posedge sysclk);
        #1;
        drive_bit(1'b0, 1'b0, P);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0, P);
        drive_bit(d[4], 1'b0, P/2);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin failures++; $display("FAIL midreset_data: got %b/%h want 0/00", rx_valid, rx_data); end
        checks++; if (sample_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_ctrl: sample_en=%b busy=%b want 0 0", sample_en, busy); end
        rx = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(2*P);
        acc0 = n_acc;
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(P);
        checks++; if (n_acc - acc0 !== 1 || last_acc !== 8'h5A) begin failures++; $display("FAIL midreset_next: got %0d/%h want 1/5a", n_acc - acc0, last_acc); end
    endtask

    initial begin
        test_reset;
        test_frame;
        test_glitch;
        test_break;
        test_overrun;
        test_parity;
        test_reset_mid;
        checks++; if (n_olap !== 0) begin failures++; $display("FAIL err_overlap: got %0d want 0", n_olap); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
